// File: rtl/rsa_key_manager.sv
`default_nettype none
// ============================================================================
//  Module   : rsa_key_manager
//  Purpose  : Key-set controller for the RSA core. Computes n = p*q and
//             phi = (p-1)*(q-1) with an iterative shift-add multiplier, hands
//             phi to the e/d key generator and holds the finished {n, e, d}.
//  Ports    : clk, rst (sync, active-high)
//             start, p, q                  - key-set request
//             phi, phi_valid               - to key generator
//             e_key_in/_valid, d_key_in/_valid - from key generator
//             n, e_key, d_key, keys_ready  - finished key set
//             busy, error                  - status
//  Options  : RSA_KM_TIMEOUT_EN enables the WAIT_KEYS watchdog
//             (TIMEOUT_CYCLES cycles without a capture -> error).
//  Revision : 1.0 - initial release
// ============================================================================
module rsa_key_manager #(
    parameter int PRIME_W        = 16,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [PRIME_W-1:0]     p,
    input  logic [PRIME_W-1:0]     q,
    output logic [2*PRIME_W-1:0]   phi,
    output logic                   phi_valid,
    input  logic [31:0]            e_key_in,
    input  logic                   e_key_valid,
    input  logic [31:0]            d_key_in,
    input  logic                   d_key_valid,
    output logic [2*PRIME_W-1:0]   n,
    output logic [31:0]            e_key,
    output logic [31:0]            d_key,
    output logic                   keys_ready,
    output logic                   busy,
    output logic                   error
);

    localparam int c_ACC_W = 2 * PRIME_W;
    localparam int c_CNT_W = $clog2(PRIME_W + 1);
    localparam logic [c_CNT_W-1:0] c_LAST_CNT = c_CNT_W'(PRIME_W);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [PRIME_W-1:0] c_ONE      = PRIME_W'(1);
    localparam logic [PRIME_W-1:0] c_MIN_PRIME = PRIME_W'(3);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_MULT = 2'd1;
    localparam logic [1:0] c_WAIT = 2'd2;
    localparam logic [1:0] c_DONE = 2'd3;

    logic [1:0]           state_q, state_d;
    logic [c_ACC_W-1:0]   p_sh_q, p_sh_d, pm1_sh_q, pm1_sh_d;
    logic [PRIME_W-1:0]   q_sh_q, q_sh_d, qm1_sh_q, qm1_sh_d;
    logic [c_ACC_W-1:0]   acc_n_q, acc_n_d, acc_phi_q, acc_phi_d;
    logic [c_ACC_W-1:0]   n_q, n_d, phi_q, phi_d;
    logic [31:0]          e_key_q, e_key_d, d_key_q, d_key_d;
    logic [c_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic                 phi_valid_q, phi_valid_d, keys_ready_q, keys_ready_d;
    logic                 busy_q, busy_d, error_q, error_d;

    logic w_primes_ok;
    logic w_capture;
    logic w_timeout;

    assign w_primes_ok = (p >= c_MIN_PRIME) && (q >= c_MIN_PRIME) && (p != q);
    // Only a joint pulse is a capture; a lone e or d pulse is dropped.
    assign w_capture   = e_key_valid && d_key_valid;

`ifdef RSA_KM_TIMEOUT_EN
    logic [31:0] wait_cnt_q, wait_cnt_d;

    // Zero outside WAIT_KEYS, so it restarts from 0 on every entry.
    always_comb begin
        wait_cnt_d = 32'd0;
        if (state_q == c_WAIT) begin
            wait_cnt_d = wait_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_q <= 32'd0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Fires on the TIMEOUT_CYCLES-th cycle spent in WAIT_KEYS.
    assign w_timeout = (wait_cnt_q == 32'(TIMEOUT_CYCLES - 1));
`else
    assign w_timeout = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= c_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_IDLE, c_DONE: begin
                if (start) begin
                    state_d = w_primes_ok ? c_MULT : c_IDLE;
                end
            end
            c_MULT: begin
                if (bit_cnt_q == c_LAST_CNT) begin
                    state_d = c_WAIT;
                end
            end
            c_WAIT: begin
                if (w_capture) begin
                    state_d = (e_key_in == 32'd0) ? c_IDLE : c_DONE;
                end else if (w_timeout) begin
                    state_d = c_IDLE;
                end
            end
            default: state_d = c_IDLE;
        endcase
    end

    // Output / datapath logic. Multiplicands shift left and multipliers shift
    // right so every MULT cycle only looks at bit 0; the extra cycle with
    // bit_cnt == PRIME_W transfers the accumulators to n/phi.
    always_comb begin
        p_sh_d       = p_sh_q;
        pm1_sh_d     = pm1_sh_q;
        q_sh_d       = q_sh_q;
        qm1_sh_d     = qm1_sh_q;
        acc_n_d      = acc_n_q;
        acc_phi_d    = acc_phi_q;
        n_d          = n_q;
        phi_d        = phi_q;
        e_key_d      = e_key_q;
        d_key_d      = d_key_q;
        bit_cnt_d    = bit_cnt_q;
        keys_ready_d = keys_ready_q;
        error_d      = error_q;
        case (state_q)
            c_IDLE, c_DONE: begin
                if (start) begin
                    keys_ready_d = 1'b0;
                    if (w_primes_ok) begin
                        error_d   = 1'b0;
                        n_d       = '0;
                        phi_d     = '0;
                        e_key_d   = 32'd0;
                        d_key_d   = 32'd0;
                        p_sh_d    = {{PRIME_W{1'b0}}, p};
                        pm1_sh_d  = {{PRIME_W{1'b0}}, p - c_ONE};
                        q_sh_d    = q;
                        qm1_sh_d  = q - c_ONE;
                        acc_n_d   = '0;
                        acc_phi_d = '0;
                        bit_cnt_d = '0;
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end
            c_MULT: begin
                if (bit_cnt_q == c_LAST_CNT) begin
                    n_d   = acc_n_q;
                    phi_d = acc_phi_q;
                end else begin
                    if (q_sh_q[0]) begin
                        acc_n_d = acc_n_q + p_sh_q;
                    end
                    if (qm1_sh_q[0]) begin
                        acc_phi_d = acc_phi_q + pm1_sh_q;
                    end
                    p_sh_d    = p_sh_q << 1;
                    pm1_sh_d  = pm1_sh_q << 1;
                    q_sh_d    = q_sh_q >> 1;
                    qm1_sh_d  = qm1_sh_q >> 1;
                    bit_cnt_d = bit_cnt_q + c_CNT_ONE;
                end
            end
            c_WAIT: begin
                // A capture on the timeout cycle takes precedence.
                if (w_capture) begin
                    if (e_key_in == 32'd0) begin
                        error_d = 1'b1;
                    end else begin
                        e_key_d      = e_key_in;
                        d_key_d      = d_key_in;
                        keys_ready_d = 1'b1;
                    end
                end else if (w_timeout) begin
                    error_d      = 1'b1;
                    keys_ready_d = 1'b0;
                end
            end
            default: ;
        endcase
        // Registered status mirrors the state being entered.
        phi_valid_d = (state_d == c_WAIT);
        busy_d      = (state_d == c_MULT) || (state_d == c_WAIT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            p_sh_q       <= '0;
            pm1_sh_q     <= '0;
            q_sh_q       <= '0;
            qm1_sh_q     <= '0;
            acc_n_q      <= '0;
            acc_phi_q    <= '0;
            n_q          <= '0;
            phi_q        <= '0;
            e_key_q      <= 32'd0;
            d_key_q      <= 32'd0;
            bit_cnt_q    <= '0;
            phi_valid_q  <= 1'b0;
            keys_ready_q <= 1'b0;
            busy_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            p_sh_q       <= p_sh_d;
            pm1_sh_q     <= pm1_sh_d;
            q_sh_q       <= q_sh_d;
            qm1_sh_q     <= qm1_sh_d;
            acc_n_q      <= acc_n_d;
            acc_phi_q    <= acc_phi_d;
            n_q          <= n_d;
            phi_q        <= phi_d;
            e_key_q      <= e_key_d;
            d_key_q      <= d_key_d;
            bit_cnt_q    <= bit_cnt_d;
            phi_valid_q  <= phi_valid_d;
            keys_ready_q <= keys_ready_d;
            busy_q       <= busy_d;
            error_q      <= error_d;
        end
    end

    assign phi        = phi_q;
    assign phi_valid  = phi_valid_q;
    assign n          = n_q;
    assign e_key      = e_key_q;
    assign d_key      = d_key_q;
    assign keys_ready = keys_ready_q;
    assign busy       = busy_q;
    assign error      = error_q;

endmodule
`default_nettype wire

// File: tb/tb_rsa_key_manager.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rsa_key_manager
//  Purpose  : Self-checking bench for rsa_key_manager. A transaction-level
//             model (products via '*', latency as a countdown) is compared
//             against every DUT output each cycle, plus literal spot checks.
//  Options  : RSA_KM_TIMEOUT_EN adds the watchdog scenarios (limit 20).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rsa_key_manager;

    localparam int PRIME_W = 16;
    localparam int TO_CYC  = 20;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] p = '0, q = '0;
    logic [31:0] e_key_in = '0, d_key_in = '0;
    logic        e_key_valid = 1'b0, d_key_valid = 1'b0;
    logic [31:0] phi, n, e_key, d_key;
    logic        phi_valid, keys_ready, busy, error;

    int checks = 0;
    int errors = 0;

    rsa_key_manager #(.PRIME_W(PRIME_W), .TIMEOUT_CYCLES(TO_CYC)) dut (
        .clk(clk), .rst(rst), .start(start), .p(p), .q(q),
        .phi(phi), .phi_valid(phi_valid),
        .e_key_in(e_key_in), .e_key_valid(e_key_valid),
        .d_key_in(d_key_in), .d_key_valid(d_key_valid),
        .n(n), .e_key(e_key), .d_key(d_key),
        .keys_ready(keys_ready), .busy(busy), .error(error)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    typedef enum int {M_IDLE, M_COMPUTE, M_WAIT, M_DONE} mode_t;
    mode_t       m_mode = M_IDLE;
    bit          m_on = 1'b0;
    int          m_left, m_tcnt;
    logic [31:0] m_n, m_phi, m_e, m_d, pend_n, pend_phi;
    logic        m_pv, m_kr, m_err;

    always @(posedge clk) begin
        if (rst) begin
            m_on = 1'b1; m_mode = M_IDLE;
            m_n = 0; m_phi = 0; m_e = 0; m_d = 0;
            m_pv = 0; m_kr = 0; m_err = 0;
        end else begin
            case (m_mode)
                M_IDLE, M_DONE: if (start) begin
                    m_kr = 0;
                    if (p < 3 || q < 3 || p == q) begin
                        m_err = 1; m_mode = M_IDLE;
                    end else begin
                        m_err = 0; m_n = 0; m_phi = 0; m_e = 0; m_d = 0;
                        pend_n   = 32'(p) * 32'(q);
                        pend_phi = (32'(p) - 1) * (32'(q) - 1);
                        m_left = PRIME_W; m_mode = M_COMPUTE;
                    end
                end
                M_COMPUTE: begin
                    if (m_left == 0) begin
                        m_n = pend_n; m_phi = pend_phi; m_pv = 1;
                        m_tcnt = 0; m_mode = M_WAIT;
                    end else begin
                        m_left--;
                    end
                end
                M_WAIT: begin
                    m_tcnt++;
                    if (e_key_valid && d_key_valid) begin
                        m_pv = 0;
                        if (e_key_in == 0) begin
                            m_err = 1; m_mode = M_IDLE;
                        end else begin
                            m_e = e_key_in; m_d = d_key_in; m_kr = 1; m_mode = M_DONE;
                        end
                    end
`ifdef RSA_KM_TIMEOUT_EN
                    else if (m_tcnt == TO_CYC) begin
                        m_err = 1; m_pv = 0; m_kr = 0; m_mode = M_IDLE;
                    end
`endif
                end
                default: m_mode = M_IDLE;
            endcase
        end
    end

    // Per-cycle comparison away from the active edge.
    always @(negedge clk) begin
        if (m_on) begin
            logic m_busy;
            m_busy = (m_mode == M_COMPUTE) || (m_mode == M_WAIT);
            checks++;
            if ({n, phi, e_key, d_key, phi_valid, keys_ready, busy, error} !==
                {m_n, m_phi, m_e, m_d, m_pv, m_kr, m_busy, m_err}) begin
                errors++;
                $display("FAIL cycle_model t=%0t: got n=%0d phi=%0d e=%0d d=%0d pv=%b kr=%b busy=%b err=%b, expected n=%0d phi=%0d e=%0d d=%0d pv=%b kr=%b busy=%b err=%b",
                         $time, n, phi, e_key, d_key, phi_valid, keys_ready, busy, error,
                         m_n, m_phi, m_e, m_d, m_pv, m_kr, m_busy, m_err);
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_start(input logic [15:0] a, input logic [15:0] b);
        start = 1'b1; p = a; q = b;
        step();
        start = 1'b0;
    endtask

    // Counts edges until phi_valid; bounded.
    task automatic wait_pv(output int lat);
        lat = 0;
        while (phi_valid !== 1'b1 && lat < 60) begin
            step(); lat++;
        end
        chk("phi_valid_wait", {31'd0, phi_valid}, 32'd1);
    endtask

    task automatic pulse(input logic [31:0] e, input logic [31:0] d,
                         input logic ev, input logic dv);
        e_key_in = e; d_key_in = d; e_key_valid = ev; d_key_valid = dv;
        step();
        e_key_valid = 1'b0; d_key_valid = 1'b0;
    endtask

    int lat;

    initial begin
        repeat (2) step();
        rst = 1'b0;
        chk("reset_n", n, 0);
        chk("reset_phi", phi, 0);
        chk("reset_flags", {28'd0, phi_valid, keys_ready, busy, error}, 0);

        // Basic key set
        do_start(16'd61, 16'd53);
        wait_pv(lat);
        chk("latency", lat, 17);
        chk("basic_phi", phi, 3120);
        chk("basic_n", n, 3233);
        chk("model_phi_pin", m_phi, 3120);
        pulse(32'd17, 32'd2753, 1'b1, 1'b1);
        chk("basic_kr", {31'd0, keys_ready}, 1);
        chk("basic_e", e_key, 17);
        chk("basic_d", d_key, 2753);
        chk("basic_pv_low", {31'd0, phi_valid}, 0);
        pulse(32'd99, 32'd98, 1'b1, 1'b1);       // ignored in DONE
        chk("done_frozen_e", e_key, 17);

        // Invalid primes
        do_start(16'd7, 16'd7);
        chk("inv_eq_err", {31'd0, error}, 1);
        chk("inv_eq_kr", {31'd0, keys_ready}, 0);
        repeat (20) step();
        chk("inv_eq_pv", {30'd0, phi_valid, busy}, 0);
        do_start(16'd2, 16'd11);
        repeat (20) step();
        chk("inv_small_err", {30'd0, phi_valid, error}, 1);

        // Start while busy
        do_start(16'd61, 16'd53);
        chk("start_clears_err", {31'd0, error}, 0);
        repeat (3) step();
        do_start(16'd11, 16'd13);
        wait_pv(lat);
        do_start(16'd11, 16'd13);
        chk("busy_phi", phi, 3120);
        chk("busy_n", n, 3233);

        // Partial key pulses
        pulse(32'd17, 32'd0, 1'b1, 1'b0);
        chk("lone_e_pv", {31'd0, phi_valid}, 1);
        pulse(32'd0, 32'd2753, 1'b0, 1'b1);
        chk("lone_d_kr", {31'd0, keys_ready}, 0);
        pulse(32'd17, 32'd2753, 1'b1, 1'b1);
        chk("joint_e", e_key, 17);
        chk("joint_d", d_key, 2753);

        // Reset mid-MULT and mid-WAIT_KEYS
        do_start(16'd61, 16'd53);
        repeat (4) step();
        rst = 1'b1; step(); rst = 1'b0;
        chk("rst_mult", {n | phi | e_key | d_key}, 0);
        chk("rst_mult_flags", {28'd0, phi_valid, keys_ready, busy, error}, 0);
        do_start(16'd61, 16'd53);
        wait_pv(lat);
        rst = 1'b1; step(); rst = 1'b0;
        chk("rst_wait_pv", {31'd0, phi_valid}, 0);
        chk("rst_wait_n", n, 0);
        do_start(16'd11, 16'd13);
        wait_pv(lat);
        chk("small_n", n, 143);
        chk("small_phi", phi, 120);

        // Zero public exponent is an error
        pulse(32'd0, 32'd5, 1'b1, 1'b1);
        chk("zero_e_err", {30'd0, keys_ready, error}, 1);
        chk("zero_e_pv", {31'd0, phi_valid}, 0);

`ifdef RSA_KM_TIMEOUT_EN
        do_start(16'd61, 16'd53);
        wait_pv(lat);
        repeat (19) step();
        chk("to_before", {31'd0, phi_valid}, 1);
        step();
        chk("to_err", {30'd0, phi_valid, error}, 1);
        do_start(16'd61, 16'd53);
        wait_pv(lat);
        repeat (19) step();
        pulse(32'd17, 32'd2753, 1'b1, 1'b1);
        chk("to_capture", {30'd0, keys_ready, error}, 2);
`endif

        repeat (3) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
